// File: rtl/tdoa_correlator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tdoa_correlator
// Description : Time-multiplexed cross-correlator. Accumulates ref*tap[k] for
//               every lag over a window of WIN accepted samples using one
//               shared saturating MAC, then scans for the largest
//               accumulator and reports its lag and value.
// Revision    : 1.0 - initial release
// ============================================================================
module tdoa_correlator #(
  parameter int N     = 20,
  parameter int L     = 10,
  parameter int WIN   = 256,
  parameter int ACC_W = 32,
  parameter int LAG_W = $clog2(N)
) (
  input  logic                 clk_clk,
  input  logic                 reset_n,
  input  logic                 sample_valid,
  input  logic [L-1:0]         ref_sample,
  input  logic [N*(L+1)-1:0]   tap_bus,
  output logic                 busy,
  output logic                 result_valid,
  output logic [LAG_W-1:0]     best_lag,
  output logic [ACC_W-1:0]     best_peak,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAC    = 2'd1,
    S_SCAN   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [L-1:0]       r_ref;
  logic [L:0]         r_tap [N];
  logic [ACC_W-1:0]   r_acc [N];
  logic [LAG_W-1:0]   r_lag;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_max;
  logic [LAG_W-1:0]   r_max_lag;
  logic               r_result_valid;
  logic [LAG_W-1:0]   r_best_lag;
  logic [ACC_W-1:0]   r_best_peak;
  logic               r_overrun;

  logic               w_last_lag;
  logic               w_win_done;
  logic [L:0]         w_tap;
  logic [ACC_W-1:0]   w_acc_cur;
  logic [2*L:0]       w_prod;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_sat;

  // Shared MAC datapath: product of held reference and the tap of the current
  // lag, added to that lag's accumulator with clamping at all-ones.
  always_comb begin
    w_last_lag = (r_lag == LAG_W'(N - 1));
    w_win_done = (r_cnt == CNT_W'(WIN - 1));
    w_tap      = r_tap[r_lag];
    w_acc_cur  = r_acc[r_lag];
    w_prod     = {{(L+1){1'b0}}, r_ref} * {{L{1'b0}}, w_tap};
    w_sum      = {1'b0, w_acc_cur} + {{(ACC_W-2*L){1'b0}}, w_prod};
    w_acc_sat  = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  end

  // State register.
  always_ff @(posedge clk_clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: one MAC pass per sample, scan and report after WIN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (sample_valid) w_next = S_MAC;
      S_MAC:    if (w_last_lag) w_next = w_win_done ? S_SCAN : S_IDLE;
      S_SCAN:   if (w_last_lag) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: sample capture, accumulation, max scan, result and overrun.
  always_ff @(posedge clk_clk) begin
    if (!reset_n) begin
      r_ref          <= '0;
      r_lag          <= '0;
      r_cnt          <= '0;
      r_max          <= '0;
      r_max_lag      <= '0;
      r_result_valid <= 1'b0;
      r_best_lag     <= '0;
      r_best_peak    <= '0;
      r_overrun      <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_tap[k] <= '0;
        r_acc[k] <= '0;
      end
    end else begin
      r_result_valid <= 1'b0;
      if (sample_valid && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_lag <= '0;
          if (sample_valid) begin
            r_ref <= ref_sample;
            for (int k = 0; k < N; k++) r_tap[k] <= tap_bus[k*(L+1) +: (L+1)];
          end
        end
        S_MAC: begin
          r_acc[r_lag] <= w_acc_sat;
          if (w_last_lag) begin
            r_lag <= '0;
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_lag <= r_lag + LAG_W'(1);
          end
        end
        S_SCAN: begin
          // Strictly-greater update keeps the lowest lag on ties.
          if ((r_lag == '0) || (w_acc_cur > r_max)) begin
            r_max     <= w_acc_cur;
            r_max_lag <= r_lag;
          end
          r_lag <= w_last_lag ? '0 : r_lag + LAG_W'(1);
        end
        S_REPORT: begin
          r_best_lag     <= r_max_lag;
          r_best_peak    <= r_max;
          r_result_valid <= 1'b1;
          r_cnt          <= '0;
          for (int k = 0; k < N; k++) r_acc[k] <= '0;
        end
        default: r_lag <= '0;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign result_valid = r_result_valid;
  assign best_lag     = r_best_lag;
  assign best_peak    = r_best_peak;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
